// File: rtl/nios_sample_fifo_pio_pkg.sv
// Shared register map, bit positions and control layout for the sample FIFO PIO.
package nios_sample_fifo_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_THRESHOLD = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUT       = 3'd4;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERFLOW  = 2;
  localparam int unsigned STAT_UNDERFLOW = 3;
  localparam int unsigned STAT_LEVEL_LSB = 16;

  localparam int unsigned CTRL_CAPTURE_EN = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_FLUSH      = 2;

  typedef struct packed {
    logic irq_en;
    logic capture_en;
  } ctrl_t;

endpackage

// File: rtl/nios_sample_fifo_pio_if.sv
// Avalon-MM slave bus bundle for the sample FIFO PIO.
interface nios_sample_fifo_pio_if;
  import nios_sample_fifo_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_sample_fifo_mem.sv
// Synchronous FIFO storage: wrapping pointers, explicit fill level, flush has top priority.
module nios_sample_fifo_mem #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned LEVEL_WIDTH = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]  head_o,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   do_push, do_pop;

  always_comb begin
    do_push = push_i & ~flush_i;
    do_pop  = pop_i & ~flush_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
        2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; the level gates every observable read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LEVEL_WIDTH'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/nios_sample_fifo_pio.sv
// Avalon-MM PIO: buffers strobed ADC samples in a FIFO, exposes status/control,
// a fill-level threshold interrupt, sticky error flags and a general-purpose output.
module nios_sample_fifo_pio
  import nios_sample_fifo_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned LEVEL_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios_sample_fifo_pio_if.slave bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  sample_strobe,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  logic rd_req, wr_req, data_rd, pop, push, drop, flush;

  logic [DATA_WIDTH-1:0]  head;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   full, empty;

  ctrl_t                  ctrl_q, ctrl_d;
  logic                   ovf_q, ovf_d, unf_q, unf_d;
  logic [LEVEL_WIDTH-1:0] thr_q, thr_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic                   irq_q, irq_d;
  logic [BUS_W-1:0]       rdata_q, rdata_d;

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // A full FIFO still accepts a sample when the same cycle pops one.
  always_comb begin
    rd_req  = bus.chipselect & ~bus.read_n;
    wr_req  = bus.chipselect & ~bus.write_n;
    data_rd = rd_req & (bus.address == ADDR_DATA);
    pop     = data_rd & ~empty;
    flush   = wr_req & (bus.address == ADDR_CONTROL) & bus.writedata[CTRL_FLUSH];
    push    = sample_strobe & ctrl_q.capture_en & (~full | pop);
    drop    = sample_strobe & ctrl_q.capture_en & full & ~pop;
  end

  nios_sample_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEVEL_WIDTH(LEVEL_WIDTH)
  ) u_mem (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .wdata_i(in_port),
    .head_o (head),
    .level_o(level),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    thr_d  = thr_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (wr_req) begin
      case (bus.address)
        ADDR_STATUS: begin
          if (bus.writedata[STAT_OVERFLOW])  ovf_d = 1'b0;
          if (bus.writedata[STAT_UNDERFLOW]) unf_d = 1'b0;
        end
        ADDR_CONTROL: begin
          ctrl_d.capture_en = bus.writedata[CTRL_CAPTURE_EN];
          ctrl_d.irq_en     = bus.writedata[CTRL_IRQ_EN];
        end
        ADDR_THRESHOLD: thr_d = bus.writedata[LEVEL_WIDTH-1:0];
        ADDR_OUT:       out_d = bus.writedata[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
    // A new error event wins over a simultaneous clear.
    if (drop)            ovf_d = 1'b1;
    if (data_rd & empty) unf_d = 1'b1;
    irq_d = ctrl_q.irq_en & (((thr_q != '0) & (level >= thr_q)) | ovf_q);
  end

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (bus.address)
        ADDR_DATA: if (!empty) rdata_d[DATA_WIDTH-1:0] = head;
        ADDR_STATUS: begin
          rdata_d[STAT_EMPTY]                       = empty;
          rdata_d[STAT_FULL]                        = full;
          rdata_d[STAT_OVERFLOW]                    = ovf_q;
          rdata_d[STAT_UNDERFLOW]                   = unf_q;
          rdata_d[STAT_LEVEL_LSB +: LEVEL_WIDTH]    = level;
        end
        ADDR_CONTROL: begin
          rdata_d[CTRL_CAPTURE_EN] = ctrl_q.capture_en;
          rdata_d[CTRL_IRQ_EN]     = ctrl_q.irq_en;
        end
        ADDR_THRESHOLD: rdata_d[LEVEL_WIDTH-1:0] = thr_q;
        ADDR_OUT:       rdata_d[DATA_WIDTH-1:0]  = out_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      thr_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      thr_q   <= thr_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign out_port     = out_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_nios_sample_fifo_pio.sv
// Scoreboard bench for nios_sample_fifo_pio: queue-based reference model, randomized traffic.
module tb_nios_sample_fifo_pio;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned LW    = 7;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_port;
  logic          sample_strobe;
  logic [DW-1:0] out_port;
  logic          irq;

  always #5 clk = ~clk;

  nios_sample_fifo_pio_if bus_if ();

  nios_sample_fifo_pio #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .LEVEL_WIDTH(LW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if),
    .in_port      (in_port),
    .sample_strobe(sample_strobe),
    .out_port     (out_port),
    .irq          (irq)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  int          model_q[$];
  bit          m_cap, m_ien, m_ovf, m_unf;
  int          m_thr;
  logic [31:0] m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_cap = 0; m_ien = 0; m_ovf = 0; m_unf = 0; m_thr = 0; m_out = '0;
  endtask

  function automatic logic [31:0] model_read(input int addr);
    int sz;
    int st;
    sz = model_q.size();
    case (addr)
      0: return (sz > 0) ? 32'(model_q[0]) : 32'd0;
      1: begin
        st = sz * 65536 + (m_unf ? 8 : 0) + (m_ovf ? 4 : 0) + ((sz == DEPTH) ? 2 : 0)
             + ((sz == 0) ? 1 : 0);
        return 32'(st);
      end
      2: return 32'((m_ien ? 2 : 0) + (m_cap ? 1 : 0));
      3: return 32'(m_thr);
      4: return m_out;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, predict, advance one clock, check irq/out_port.
  task automatic cyc(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                     input bit stb, input int smp);
    bit cap, do_pop, flush, irq_exp;
    int sz, tmp;
    bus_if.chipselect = rd | wr;
    bus_if.read_n     = !rd;
    bus_if.write_n    = !wr;
    bus_if.address    = 3'(addr);
    bus_if.writedata  = wd;
    sample_strobe     = stb;
    in_port           = DW'(smp);
    if (rd) exp_q.push_back(model_read(addr));
    sz      = model_q.size();
    cap     = m_cap;
    irq_exp = m_ien && ((m_thr != 0 && sz >= m_thr) || m_ovf);
    do_pop  = rd && addr == 0 && sz > 0;
    flush   = wr && addr == 2 && wd[2];
    if (wr) begin
      case (addr)
        1: begin
          if (wd[2]) m_ovf = 0;
          if (wd[3]) m_unf = 0;
        end
        2: begin
          m_cap = wd[0];
          m_ien = wd[1];
        end
        3: m_thr = int'(wd[LW-1:0]);
        4: m_out = {16'h0, wd[15:0]};
        default: ;
      endcase
    end
    if (stb && cap && sz == DEPTH && !do_pop) m_ovf = 1;
    if (rd && addr == 0 && sz == 0) m_unf = 1;
    if (flush) model_q.delete();
    else begin
      if (do_pop) tmp = model_q.pop_front();
      if (stb && cap && (sz < DEPTH || do_pop)) model_q.push_back(smp & 16'hFFFF);
    end
    @(posedge clk);
    #1;
    chk("irq", {31'b0, irq}, {31'b0, irq_exp});
    chk("out_port", 32'(out_port), m_out);
  endtask

  task automatic rd_reg(input int addr);
    cyc(1, 0, addr, 32'd0, 0, 0);
  endtask

  task automatic wr_reg(input int addr, input logic [31:0] wd);
    cyc(0, 1, addr, wd, 0, 0);
  endtask

  task automatic strobe(input int smp);
    cyc(0, 0, 0, 32'd0, 1, smp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 32'd0, 0, 0);
  endtask

  // Monitor: a read issued in cycle N is checked against the scoreboard in cycle N+1.
  logic was_rd;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) was_rd <= 1'b0;
    else          was_rd <= bus_if.chipselect & ~bus_if.read_n;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n) begin
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=%h required=<queued value>", bus_if.readdata);
        end else begin
          e = exp_q.pop_front();
          chk("readdata", bus_if.readdata, e);
        end
      end else begin
        chk("readdata_idle", bus_if.readdata, 32'd0);
      end
    end
  end

  initial begin
    int r, a;
    bit stb;
    logic [31:0] wd;
    reset_n              = 1'b0;
    bus_if.chipselect    = 1'b0;
    bus_if.read_n        = 1'b1;
    bus_if.write_n       = 1'b1;
    bus_if.address       = '0;
    bus_if.writedata     = '0;
    sample_strobe        = 1'b0;
    in_port              = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_readdata", bus_if.readdata, 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);

    for (int i = 0; i < 8; i++) rd_reg(i);
    idle(1);

    // Basic ordered capture, then underflow
    wr_reg(2, 32'h1);
    strobe(16'h0011);
    strobe(16'h0022);
    strobe(16'h0033);
    rd_reg(1);
    for (int i = 0; i < 4; i++) rd_reg(0);
    rd_reg(1);

    // Fill to full, overflow on the 65th sample
    for (int i = 0; i < DEPTH; i++) strobe(16'h1000 + i);
    strobe(16'hBEEF);
    rd_reg(1);
    wr_reg(1, 32'h4);
    rd_reg(1);
    // Full: simultaneous push and pop keeps level, no overflow
    cyc(1, 0, 0, 32'd0, 1, 16'h7777);
    rd_reg(1);
    for (int i = 0; i < DEPTH; i++) rd_reg(0);
    rd_reg(1);
    wr_reg(1, 32'hC);

    // Threshold interrupt
    wr_reg(3, 32'd8);
    wr_reg(2, 32'h3);
    for (int i = 0; i < 8; i++) strobe(16'h2000 + i);
    idle(2);
    rd_reg(0);
    idle(2);

    // General-purpose output and flush racing a strobe
    wr_reg(4, 32'hFFFF_A5A5);
    rd_reg(4);
    strobe(16'h3001);
    strobe(16'h3002);
    cyc(0, 1, 2, 32'h7, 1, 16'h3003);
    rd_reg(1);
    rd_reg(2);
    rd_reg(0);
    strobe(16'h3004);
    idle(1);

    // Asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    chk("midrst_readdata", bus_if.readdata, 32'd0);
    chk("midrst_out_port", 32'(out_port), 32'd0);
    chk("midrst_irq", {31'b0, irq}, 32'd0);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd_reg(1);
    rd_reg(4);

    // Randomized traffic
    wr_reg(2, 32'h1);
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 99);
      stb = ($urandom_range(0, 99) < ((i < 1500) ? 45 : 20));
      wd  = $urandom;
      if (r < 45) begin
        a = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 7);
        cyc(1, 0, a, 32'd0, stb, $urandom_range(0, 65535));
      end else if (r < 55) begin
        a = $urandom_range(0, 7);
        if (a == 2) begin
          wd[0] = ($urandom_range(0, 9) != 0);
          wd[2] = ($urandom_range(0, 15) == 0);
        end
        cyc(0, 1, a, wd, stb, $urandom_range(0, 65535));
      end else begin
        cyc(0, 0, 0, 32'd0, stb, $urandom_range(0, 65535));
      end
    end
    rd_reg(1);
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
